multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multicycle successor to the single-cycle RV32I control unit.
- Moore FSM that sequences fetch/decode/execute/memory/writeback over several cycles, sharing one ALU and one memory port.
- Adds a memory ready handshake, full branch set (beq/bne/blt/bge/bltu/bgeu), and jalr/lui/auipc support.
- Sits between the instruction register and the multicycle datapath.

Parameters:
ALU_CTRL_W, 4, ALUControl width; must be >=4, upper bits zero-filled
IMM_SRC_W, 3, ImmSrc width; must be >=3

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op  in  7  instruction opcode (from IR)
funct3  in  3  instruction funct3
funct7b5  in  1  instruction bit 30
Zero, Negative, Carry, Overflow  in  1 each  ALU flags of the current cycle; Carry=1 means no borrow on subtract
mem_ready  in  1  memory completed the access requested this cycle
mem_req  out  1  memory access request
MemWrite  out  1  store strobe; valid only with mem_req
AdrSrc  out  1  0=PC, 1=Result
IRWrite  out  1  load IR and OldPC
PCWrite  out  1  load PC from Result
RegWrite  out  1  register file write
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rd1
ALUSrcB  out  2  00 rd2, 01 ImmExt, 10 const 4
ImmSrc  out  IMM_SRC_W  000 I, 001 S, 010 B, 011 J, 100 U; decoded from op in every state
ALUControl  out  ALU_CTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
illegal_instr  out  1  sticky illegal-opcode flag

Behaviour:
- Single state register, updated on the rising clk edge. Outputs are a Moore function of state, plus flags in BRANCH and mem_ready in memory states.
- reset: state<=FETCH. While reset is high, all strobes are forced to 0: mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal_instr. Mux selects read 0.
- Reset mid-access abandons the access; no strobe is issued in the reset cycle.
- ALUOp: 00 add, 01 sub, 10 decode funct3.
  - funct3=000 decodes to sub only when op[5]&funct7b5; funct3=101 decodes to sra when funct7b5.
- FETCH: mem_req, AdrSrc0, SrcA00, SrcB10, add, ResultSrc10. IRWrite and PCWrite assert only in the cycle mem_ready=1, then go to DECODE; otherwise stay in FETCH.
- DECODE: SrcA01, SrcB01, add (ALUOut<=OldPC+imm). Next state by op:
  - lw/sw -> MEMADR
  - R -> EXECR
  - I-alu -> EXECI
  - branch -> BRANCH
  - jal -> JAL
  - jalr -> JALR
  - lui -> LUI
  - auipc -> ALUWB
  - other -> see optional feature
- MEMADR: SrcA10, SrcB01, add; -> MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_req, AdrSrc1, ResultSrc00; waits for mem_ready, then -> MEMWB.
- MEMWB: ResultSrc01, RegWrite; -> FETCH.
- MEMWRITE: mem_req, MemWrite, AdrSrc1, ResultSrc00; waits for mem_ready, then -> FETCH.
- EXECR: SrcA10, SrcB00, ALUOp10; -> ALUWB.
- EXECI: SrcA10, SrcB01, ALUOp10; -> ALUWB.
- ALUWB: ResultSrc00, RegWrite; -> FETCH.
- BRANCH: SrcA10, SrcB00, sub, ResultSrc00. PCWrite = taken, where taken is decoded from funct3:
  - 000 Zero
  - 001 ~Zero
  - 100 N^V
  - 101 ~(N^V)
  - 110 ~Carry
  - 111 Carry
  - 010/011: never taken
  - -> FETCH.
- JALR: SrcA10, SrcB01, add (ALUOut<=rs1+imm); -> JAL.
- JAL: SrcA01, SrcB10, add, ResultSrc00, PCWrite (PC<=ALUOut target, ALUResult=OldPC+4 latched); -> ALUWB.
- LUI: ResultSrc11, RegWrite; -> FETCH.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored. Waits are unbounded.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an unrecognised op in DECODE -> TRAP. TRAP drives all strobes 0, sets illegal_instr=1, and holds until reset.
- Undefined: unrecognised op -> FETCH (treated as NOP). illegal_instr tied 0; TRAP state not compiled.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum
  - opcode constants
  - ALUOp, ALUControl, ImmSrc, ResultSrc, ALUSrcA/B encodings
- One combinational sub-module, mc_alu_decoder: (op5, funct3, funct7b5, ALUOp) -> ALUControl, width ALU_CTRL_W.

Test Plan:
- reset 2 cycles, then add x3,x1,x2 with mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB; RegWrite=1 in cycle 4 only, ALUControl=1 never asserted.
- lw with mem_ready held 0 for 3 cycles in MEMREAD -> mem_req=1, AdrSrc=1 for 4 cycles, MEMWB entered only after ready; no RegWrite earlier.
- blt with Negative=1, Overflow=0 -> PCWrite=1 in BRANCH; bgeu with Carry=0 -> PCWrite=0; funct3=010 -> PCWrite=0.
- jalr -> DECODE, JALR, JAL, ALUWB; PCWrite in JAL, RegWrite in ALUWB with ResultSrc=00.
- reset asserted in MEMWRITE while mem_ready=1 -> MemWrite=0 that cycle, state FETCH next.
- op=0000000 -> ILLEGAL_TRAP_EN: illegal_instr=1 and stuck until reset; without the macro: returns to FETCH, illegal_instr=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the multicycle RV32I control unit
//
// Purpose: FSM state enum, opcode constants and the select/operation codes
// driven by multicycle_controller and mc_alu_decoder.
// Ports: none (package).
// Build option: ILLEGAL_TRAP_EN adds the ST_TRAP state.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_JALR     = 4'd11,
    ST_LUI      = 4'd12
`ifdef ILLEGAL_TRAP_EN
    ,
    ST_TRAP     = 4'd13
`endif
  } state_t;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALUOp
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUControl (base 4-bit code, zero-extended to ALU_CTRL_W)
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  // ImmSrc (base 3-bit code, zero-extended to IMM_SRC_W)
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_IMMEXT = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  // Immediate format is a pure function of the opcode so the extender can
  // be steered in every state, including FETCH/DECODE.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:           return IMM_S;
      OP_BRANCH:          return IMM_B;
      OP_JAL:             return IMM_J;
      OP_LUI, OP_AUIPC:   return IMM_U;
      default:            return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - ALUOp/funct decode to ALUControl
//
// Purpose: combinational ALU operation decode for the multicycle controller.
// Ports:
//   op5         in   opcode bit 5 (1 = register-register form)
//   funct3      in   instruction funct3
//   funct7b5    in   instruction bit 30
//   alu_op      in   00 add, 01 sub, 10 decode funct3
//   alu_control out  ALU operation code, upper bits zero
module mc_alu_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  op5,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic [1:0]            alu_op,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  logic [3:0] w_code;

  always_comb begin
    w_code = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: w_code = ALU_ADD;
      ALUOP_SUB: w_code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // addi has bit 30 as part of its immediate, so only the R form subtracts
          3'b000:  w_code = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  w_code = ALU_SLL;
          3'b010:  w_code = ALU_SLT;
          3'b011:  w_code = ALU_SLTU;
          3'b100:  w_code = ALU_XOR;
          3'b101:  w_code = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  w_code = ALU_OR;
          default: w_code = ALU_AND;
        endcase
      end
      default: w_code = ALU_ADD;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(w_code);

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM
//
// Purpose: Moore FSM sequencing fetch/decode/execute/memory/writeback over a
// shared ALU and single memory port, with a memory ready handshake.
// Build option: ILLEGAL_TRAP_EN - unknown opcodes enter a sticky TRAP state
// and raise illegal_instr; otherwise they are retired as NOPs.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   op, funct3, funct7b5            instruction fields from IR
//   Zero, Negative, Carry, Overflow ALU flags of the current cycle
//   mem_ready                       memory completed the requested access
//   mem_req, MemWrite, AdrSrc       memory request, store strobe, address select
//   IRWrite, PCWrite, RegWrite      IR/OldPC load, PC load, register write
//   ResultSrc, ALUSrcA, ALUSrcB     datapath mux selects
//   ImmSrc, ALUControl              immediate format, ALU operation
//   illegal_instr                   sticky illegal-opcode flag
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int IMM_SRC_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  Zero,
  input  logic                  Negative,
  input  logic                  Carry,
  input  logic                  Overflow,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  MemWrite,
  output logic                  AdrSrc,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [IMM_SRC_W-1:0]  ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  illegal_instr
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_alu_op;
  logic       w_taken;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH:    w_next = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = ST_MEMADR;
          OP_R:              w_next = ST_EXECR;
          OP_I_ALU:          w_next = ST_EXECI;
          OP_BRANCH:         w_next = ST_BRANCH;
          OP_JAL:            w_next = ST_JAL;
          OP_JALR:           w_next = ST_JALR;
          OP_LUI:            w_next = ST_LUI;
          OP_AUIPC:          w_next = ST_ALUWB;
`ifdef ILLEGAL_TRAP_EN
          default:           w_next = ST_TRAP;
`else
          default:           w_next = ST_FETCH;
`endif
        endcase
      end
      // IR is stable through MEMADR, so op still tells load from store
      ST_MEMADR:   w_next = (op == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD:  w_next = mem_ready ? ST_MEMWB : ST_MEMREAD;
      ST_MEMWB:    w_next = ST_FETCH;
      ST_MEMWRITE: w_next = mem_ready ? ST_FETCH : ST_MEMWRITE;
      ST_EXECR:    w_next = ST_ALUWB;
      ST_EXECI:    w_next = ST_ALUWB;
      ST_ALUWB:    w_next = ST_FETCH;
      ST_BRANCH:   w_next = ST_FETCH;
      ST_JALR:     w_next = ST_JAL;
      ST_JAL:      w_next = ST_ALUWB;
      ST_LUI:      w_next = ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
      ST_TRAP:     w_next = ST_TRAP;
`endif
      default:     w_next = ST_FETCH;
    endcase
  end

  // Branch condition; Carry=1 means no borrow, i.e. rs1 >= rs2 unsigned
  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken = Zero;
      3'b001:  w_taken = ~Zero;
      3'b100:  w_taken = Negative ^ Overflow;
      3'b101:  w_taken = ~(Negative ^ Overflow);
      3'b110:  w_taken = ~Carry;
      3'b111:  w_taken = Carry;
      default: w_taken = 1'b0;
    endcase
  end

  // Output logic
  always_comb begin
    mem_req       = 1'b0;
    MemWrite      = 1'b0;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    RegWrite      = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RD2;
    w_alu_op      = ALUOP_ADD;
    illegal_instr = 1'b0;
    ImmSrc        = IMM_SRC_W'(imm_src_of(op));
    case (r_state)
      ST_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      ST_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMMEXT;
      end
      ST_MEMADR, ST_JALR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMMEXT;
      end
      ST_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      ST_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      ST_MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      ST_EXECR: begin
        ALUSrcA  = SRCA_RD1;
        w_alu_op = ALUOP_FUNCT;
      end
      ST_EXECI: begin
        ALUSrcA  = SRCA_RD1;
        ALUSrcB  = SRCB_IMMEXT;
        w_alu_op = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        RegWrite = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA  = SRCA_RD1;
        w_alu_op = ALUOP_SUB;
        PCWrite  = w_taken;
      end
      // ALUOut already holds the target; ALUResult = OldPC+4 becomes rd
      ST_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      ST_LUI: begin
        ResultSrc = RES_IMMEXT;
        RegWrite  = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      ST_TRAP: begin
        illegal_instr = 1'b1;
      end
`endif
      default: begin
        mem_req = 1'b0;
      end
    endcase

    // Reset overrides the state decode so an in-flight access is dropped
    // without a strobe; ALUOp add encodes to an all-zero ALUControl.
    if (reset) begin
      mem_req       = 1'b0;
      MemWrite      = 1'b0;
      AdrSrc        = 1'b0;
      IRWrite       = 1'b0;
      PCWrite       = 1'b0;
      RegWrite      = 1'b0;
      ResultSrc     = '0;
      ALUSrcA       = '0;
      ALUSrcB       = '0;
      ImmSrc        = '0;
      w_alu_op      = ALUOP_ADD;
      illegal_instr = 1'b0;
    end
  end

  mc_alu_decoder #(
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_decoder (
    .op5         (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_op      (w_alu_op),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero, Negative, Carry, Overflow;
  logic       mem_ready;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       illegal_instr;

  always #5 clk = ~clk;

  multicycle_controller #(.ALU_CTRL_W(4), .IMM_SRC_W(3)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal_instr(illegal_instr)
  );

  localparam logic [6:0] L_LOAD = 7'b0000011, L_STORE = 7'b0100011;
  localparam logic [6:0] L_R    = 7'b0110011, L_I     = 7'b0010011;
  localparam logic [6:0] L_BR   = 7'b1100011, L_JAL   = 7'b1101111;
  localparam logic [6:0] L_JALR = 7'b1100111, L_LUI   = 7'b0110111;
  localparam logic [6:0] L_AUI  = 7'b0010111;

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, src_a, src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_ctrl;
    logic       illegal;
  } exp_t;

  typedef enum {K_RST, K_FETCH, K_DECODE, K_MEMADR, K_MEMREAD, K_MEMWB,
                K_MEMWRITE, K_EXECR, K_EXECI, K_ALUWB, K_BRANCH, K_JAL,
                K_JALR, K_LUI, K_TRAP} kind_t;

  int    total = 0;
  int    bad   = 0;
  exp_t  exp_q[$];
  string name_q[$];
  exp_t  c_exp, c_act, m;
  string c_name;

  // values to present on the IR/flag inputs from the next cycle on
  logic [6:0] n_op;
  logic [2:0] n_f3;
  logic       n_f7;
  logic [3:0] n_flg;

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    if (o == L_STORE) return 3'b001;
    if (o == L_BR) return 3'b010;
    if (o == L_JAL) return 3'b011;
    if (o == L_LUI || o == L_AUI) return 3'b100;
    return 3'b000;
  endfunction

  // operation named by the instruction mnemonic
  function automatic logic [3:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (o == L_R && f7) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7 ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // flg = {Z,N,C,V}; compare outcome of rs1 vs rs2 after a subtract
  function automatic logic taken_of(input logic [2:0] f3, input logic [3:0] flg);
    logic z, n, c, v;
    {z, n, c, v} = flg;
    case (f3)
      3'b000: return z;          // equal
      3'b001: return !z;         // not equal
      3'b100: return n != v;     // signed less
      3'b101: return n == v;     // signed greater-or-equal
      3'b110: return !c;         // unsigned less (borrow)
      3'b111: return c;          // unsigned greater-or-equal
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(input kind_t k, input logic rdy, input logic rst,
                                 input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic [3:0] flg);
    exp_t e;
    e = '0;
    if (rst) return e;
    e.imm_src = imm_of(o);
    case (k)
      K_FETCH:    begin e.mem_req = 1; e.src_b = 2'b10; e.result_src = 2'b10;
                        e.ir_write = rdy; e.pc_write = rdy; end
      K_DECODE:   begin e.src_a = 2'b01; e.src_b = 2'b01; end
      K_MEMADR,
      K_JALR:     begin e.src_a = 2'b10; e.src_b = 2'b01; end
      K_MEMREAD:  begin e.mem_req = 1; e.adr_src = 1; end
      K_MEMWB:    begin e.result_src = 2'b01; e.reg_write = 1; end
      K_MEMWRITE: begin e.mem_req = 1; e.mem_write = 1; e.adr_src = 1; end
      K_EXECR:    begin e.src_a = 2'b10; e.alu_ctrl = alu_of(o, f3, f7); end
      K_EXECI:    begin e.src_a = 2'b10; e.src_b = 2'b01; e.alu_ctrl = alu_of(o, f3, f7); end
      K_ALUWB:    e.reg_write = 1;
      K_BRANCH:   begin e.src_a = 2'b10; e.alu_ctrl = 4'd1; e.pc_write = taken_of(f3, flg); end
      K_JAL:      begin e.src_a = 2'b01; e.src_b = 2'b10; e.pc_write = 1; end
      K_LUI:      begin e.result_src = 2'b11; e.reg_write = 1; end
      K_TRAP:     e.illegal = 1;
      default:    e = '0;
    endcase
    return e;
  endfunction

  // compare process: one expectation per cycle, sampled mid low phase
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      c_exp  = exp_q.pop_front();
      c_name = name_q.pop_front();
      c_act  = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr};
      total++;
      if (c_act !== c_exp) begin
        bad++;
        $display("FAIL %s: got %b required %b", c_name, c_act, c_exp);
      end
    end
  end

  task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, got, want);
    end
  endtask

  task automatic cyc(input kind_t k, input logic rdy, input logic rst, input string nm);
    @(posedge clk);
    #1;
    reset = rst; mem_ready = rdy;
    op = n_op; funct3 = n_f3; funct7b5 = n_f7;
    {Zero, Negative, Carry, Overflow} = n_flg;
    exp_q.push_back(model(k, rdy, rst, n_op, n_f3, n_f7, n_flg));
    name_q.push_back(nm);
  endtask

  // fw/mw: cycles of mem_ready=0 before the fetch / data access completes
  task automatic run(input string nm, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic [3:0] flg, input int fw,
                     input int mw, input bit rst_mid);
    n_op = o; n_f3 = f3; n_f7 = f7; n_flg = flg;
    for (int i = 0; i < fw; i++) cyc(K_FETCH, 1'b0, 1'b0, {nm, "/fetch_wait"});
    cyc(K_FETCH, 1'b1, 1'b0, {nm, "/fetch"});
    cyc(K_DECODE, 1'b1, 1'b0, {nm, "/decode"});
    case (o)
      L_LOAD: begin
        cyc(K_MEMADR, 1'b1, 1'b0, {nm, "/memadr"});
        for (int i = 0; i < mw; i++) cyc(K_MEMREAD, 1'b0, 1'b0, {nm, "/memread_wait"});
        cyc(K_MEMREAD, 1'b1, 1'b0, {nm, "/memread"});
        cyc(K_MEMWB, 1'b1, 1'b0, {nm, "/memwb"});
      end
      L_STORE: begin
        cyc(K_MEMADR, 1'b1, 1'b0, {nm, "/memadr"});
        if (rst_mid) begin
          cyc(K_MEMWRITE, 1'b0, 1'b0, {nm, "/memwrite_wait"});
          cyc(K_RST, 1'b1, 1'b1, {nm, "/reset_in_memwrite"});
        end else begin
          for (int i = 0; i < mw; i++) cyc(K_MEMWRITE, 1'b0, 1'b0, {nm, "/memwrite_wait"});
          cyc(K_MEMWRITE, 1'b1, 1'b0, {nm, "/memwrite"});
        end
      end
      L_R: begin
        cyc(K_EXECR, 1'b1, 1'b0, {nm, "/execr"});
        cyc(K_ALUWB, 1'b1, 1'b0, {nm, "/aluwb"});
      end
      L_I: begin
        cyc(K_EXECI, 1'b1, 1'b0, {nm, "/execi"});
        cyc(K_ALUWB, 1'b1, 1'b0, {nm, "/aluwb"});
      end
      L_BR:   cyc(K_BRANCH, 1'b1, 1'b0, {nm, "/branch"});
      L_JAL: begin
        cyc(K_JAL, 1'b1, 1'b0, {nm, "/jal"});
        cyc(K_ALUWB, 1'b1, 1'b0, {nm, "/aluwb"});
      end
      L_JALR: begin
        cyc(K_JALR, 1'b1, 1'b0, {nm, "/jalr"});
        cyc(K_JAL, 1'b1, 1'b0, {nm, "/jal"});
        cyc(K_ALUWB, 1'b1, 1'b0, {nm, "/aluwb"});
      end
      L_LUI:  cyc(K_LUI, 1'b1, 1'b0, {nm, "/lui"});
      L_AUI:  cyc(K_ALUWB, 1'b1, 1'b0, {nm, "/aluwb"});
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) cyc(K_TRAP, 1'b1, 1'b0, {nm, "/trap"});
        cyc(K_RST, 1'b1, 1'b1, {nm, "/trap_reset"});
`endif
      end
    endcase
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0;
    {Zero, Negative, Carry, Overflow} = 4'b0000;
    n_op = '0; n_f3 = '0; n_f7 = 1'b0; n_flg = 4'b0000;

    // literal pins on the model
    m = model(K_FETCH, 1'b1, 1'b0, L_R, 3'b000, 1'b0, 4'b0000);
    pin("model_fetch_vector", 32'(m), 32'h9A200);
    m = model(K_EXECR, 1'b1, 1'b0, L_R, 3'b000, 1'b1, 4'b0000);
    pin("model_sub_aluctrl", 32'(m.alu_ctrl), 32'd1);
    m = model(K_EXECI, 1'b1, 1'b0, L_I, 3'b000, 1'b1, 4'b0000);
    pin("model_addi_bit30_aluctrl", 32'(m.alu_ctrl), 32'd0);
    m = model(K_EXECI, 1'b1, 1'b0, L_I, 3'b101, 1'b1, 4'b0000);
    pin("model_srai_aluctrl", 32'(m.alu_ctrl), 32'd9);
    m = model(K_BRANCH, 1'b1, 1'b0, L_BR, 3'b100, 1'b0, 4'b0100);
    pin("model_blt_taken", 32'(m.pc_write), 32'd1);
    m = model(K_BRANCH, 1'b1, 1'b0, L_BR, 3'b111, 1'b0, 4'b0000);
    pin("model_bgeu_c0_taken", 32'(m.pc_write), 32'd0);
    m = model(K_LUI, 1'b1, 1'b0, L_LUI, 3'b000, 1'b0, 4'b0000);
    pin("model_lui_imm_res", 32'({m.imm_src, m.result_src}), 32'b10011);

    cyc(K_RST, 1'b0, 1'b1, "reset0");
    cyc(K_RST, 1'b1, 1'b1, "reset1");
    #1;
    pin("reset_strobes", 32'({mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal_instr}), 32'd0);

    run("add",       L_R,     3'b000, 1'b0, 4'b0000, 0, 0, 1'b0);
    run("sub",       L_R,     3'b000, 1'b1, 4'b0000, 2, 0, 1'b0);
    run("sltu",      L_R,     3'b011, 1'b0, 4'b0000, 0, 0, 1'b0);
    run("lw",        L_LOAD,  3'b010, 1'b0, 4'b0000, 1, 3, 1'b0);
    run("sw",        L_STORE, 3'b010, 1'b0, 4'b0000, 0, 1, 1'b0);
    run("addi_b30",  L_I,     3'b000, 1'b1, 4'b0000, 0, 0, 1'b0);
    run("srai",      L_I,     3'b101, 1'b1, 4'b0000, 0, 0, 1'b0);
    run("blt_nv10",  L_BR,    3'b100, 1'b0, 4'b0100, 0, 0, 1'b0);
    run("bgeu_c0",   L_BR,    3'b111, 1'b0, 4'b0000, 0, 0, 1'b0);
    run("br_f3_010", L_BR,    3'b010, 1'b0, 4'b1111, 0, 0, 1'b0);
    run("beq_z1",    L_BR,    3'b000, 1'b0, 4'b1000, 0, 0, 1'b0);
    run("bne_z1",    L_BR,    3'b001, 1'b0, 4'b1000, 0, 0, 1'b0);
    run("bltu_c0",   L_BR,    3'b110, 1'b0, 4'b0000, 0, 0, 1'b0);
    run("bge_nv11",  L_BR,    3'b101, 1'b0, 4'b0101, 0, 0, 1'b0);
    run("jal",       L_JAL,   3'b000, 1'b0, 4'b0000, 0, 0, 1'b0);
    run("jalr",      L_JALR,  3'b000, 1'b0, 4'b0000, 0, 0, 1'b0);
    run("lui",       L_LUI,   3'b000, 1'b0, 4'b0000, 0, 0, 1'b0);
    run("auipc",     L_AUI,   3'b000, 1'b0, 4'b0000, 1, 0, 1'b0);
    run("sw_reset",  L_STORE, 3'b010, 1'b0, 4'b0000, 0, 0, 1'b1);
    run("illegal",   7'b0000000, 3'b000, 1'b0, 4'b0000, 0, 0, 1'b0);
    run("add_after", L_R,     3'b000, 1'b0, 4'b0000, 0, 0, 1'b0);

    @(negedge clk);
    #1;
    pin("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
